// File: rtl/slow_pkg.sv
// Shared definitions for the slow-window controller: FSM encodings, source indices, default prescale.
package slow_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_EXT  = 2'd2
    } slow_state_e;

    localparam int SRC_IACK  = 0;
    localparam int SRC_VIA   = 1;
    localparam int SRC_IWM   = 2;
    localparam int SRC_SCC   = 3;
    localparam int SRC_SCSI  = 4;
    localparam int SRC_SND   = 5;
    localparam int N_SRC     = 6;

    localparam int PRE_W_DEF = 8;

endpackage

// File: rtl/slow_timer.sv
// Extension-window down-counter: load, non-wrapping decrement, terminal-count detect.
module slow_timer #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          n_por,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_por) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/slow_ctrl.sv
// Slow-window controller: forces stock-speed CPU operation around accesses to enabled slow peripherals.
// Optional trigger statistics counter built only when SLOW_STATS_EN is defined.
//
// state | meaning
// IDLE  | no slow window; CPU free to run accelerated
// HOLD  | triggering bus cycle still active
// EXT   | bus cycle ended; timer counting down the SlowTimeout extension
module slow_ctrl
    import slow_pkg::*;
#(
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic        CLK,
    input  logic        nPOR,
    input  logic        BACT,
    input  logic        IACKCS,
    input  logic        VIACS,
    input  logic        IWMCS,
    input  logic        SCCCS,
    input  logic        SCSICS,
    input  logic        SndCS,
    input  logic        SlowIACK,
    input  logic        SlowVIA,
    input  logic        SlowIWM,
    input  logic        SlowSCC,
    input  logic        SlowSCSI,
    input  logic        SlowSnd,
    input  logic        SlowClockGate,
    input  logic [3:0]  SlowTimeout,
    output logic        SlowReq,
    output logic        SlowGate,
    output logic [15:0] SlowEvents
);

    localparam int CW = 4 + PRE_W;

    slow_state_e state_q, state_d;
    logic        gate_q, gate_d;
    logic        bact_q, bact_d;

    logic [N_SRC-1:0] cs_vec;
    logic [N_SRC-1:0] en_vec;
    logic             start;
    logic             hit;

    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [CW-1:0]    tmr_load_val;

    always_comb begin
        cs_vec = '0;
        en_vec = '0;
        cs_vec[SRC_IACK] = IACKCS;
        cs_vec[SRC_VIA]  = VIACS;
        cs_vec[SRC_IWM]  = IWMCS;
        cs_vec[SRC_SCC]  = SCCCS;
        cs_vec[SRC_SCSI] = SCSICS;
        cs_vec[SRC_SND]  = SndCS;
        en_vec[SRC_IACK] = SlowIACK;
        en_vec[SRC_VIA]  = SlowVIA;
        en_vec[SRC_IWM]  = SlowIWM;
        en_vec[SRC_SCC]  = SlowSCC;
        en_vec[SRC_SCSI] = SlowSCSI;
        en_vec[SRC_SND]  = SlowSnd;
    end

    // Decodes only count on the first clock of a bus cycle.
    assign bact_d = BACT;
    assign start  = BACT && !bact_q;
    assign hit    = start && |(cs_vec & en_vec);

    // Load value is one less than the window length so EXT spans exactly SlowTimeout units.
    assign tmr_load_val = {SlowTimeout, {PRE_W{1'b0}}} - CW'(1);

    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_HOLD;
                    gate_d  = SlowClockGate;
                end
            end
            ST_HOLD: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_EXT;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_EXT: begin
                if (hit) begin
                    state_d = ST_HOLD;
                    gate_d  = SlowClockGate;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            bact_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            bact_q  <= bact_d;
        end
    end

    slow_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (CLK),
        .n_por    (nPOR),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign SlowReq  = (state_q != ST_IDLE);
    assign SlowGate = SlowReq && gate_q;

`ifdef SLOW_STATS_EN
    logic [15:0] events_q, events_d;

    always_comb begin
        events_d = events_q;
        if (hit && (events_q != 16'hFFFF)) begin
            events_d = events_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nPOR) begin
            events_q <= 16'h0000;
        end else begin
            events_q <= events_d;
        end
    end

    assign SlowEvents = events_q;
`else
    assign SlowEvents = 16'h0000;
`endif

endmodule
